// File: rtl/vnode_proc_pkg.sv
// Shared constants for the LDPC variable-node processor: default widths,
// symmetric saturation limits and the one-hot vtc_en write-enable codes.
package vnode_proc_pkg;

  localparam int unsigned D_WID_DEF = 8;
  localparam int unsigned S_WID_DEF = D_WID_DEF + 2;

  // Largest magnitude a D_WID-bit message may carry; the most negative code is excluded.
  function automatic int sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  localparam int SAT_MAX_DEF = (1 << (D_WID_DEF - 1)) - 1;
  localparam int SAT_MIN_DEF = -SAT_MAX_DEF;

  localparam logic [2:0] VTC_EN_A   = 3'b001;
  localparam logic [2:0] VTC_EN_B   = 3'b010;
  localparam logic [2:0] VTC_EN_C   = 3'b100;
  localparam logic [2:0] VTC_EN_OFF = 3'b000;

endpackage

// File: rtl/vnode_sat.sv
// Symmetric saturator: narrows an S_WID signed value to D_WID bits, clamping to
// +/-(2^(D_WID-1)-1) and flagging when a clamp happened.
module vnode_sat
  import vnode_proc_pkg::*;
#(
  parameter int unsigned D_WID = D_WID_DEF,
  parameter int unsigned S_WID = S_WID_DEF
) (
  input  logic signed [S_WID-1:0] din_i,
  output logic signed [D_WID-1:0] dout_o,
  output logic                    clamp_o
);

  localparam logic signed [S_WID-1:0] MaxS = S_WID'(sat_max(D_WID));
  localparam logic signed [S_WID-1:0] MinS = -MaxS;

  always_comb begin
    dout_o  = din_i[D_WID-1:0];
    clamp_o = 1'b0;
    if (din_i > MaxS) begin
      dout_o  = MaxS[D_WID-1:0];
      clamp_o = 1'b1;
    end else if (din_i < MinS) begin
      dout_o  = MinS[D_WID-1:0];
      clamp_o = 1'b1;
    end
  end

endmodule

// File: rtl/vnode_proc.sv
// Variable-node processor: two-stage pipeline computing extrinsic messages and the
// hard decision. Define VNODE_SAT_STATS_EN to add the sat_cnt clamp counter.
module vnode_proc
  import vnode_proc_pkg::*;
#(
  parameter int unsigned D_WID = D_WID_DEF,
  parameter int unsigned S_WID = D_WID + 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [D_WID-1:0] llr_ch,
  input  logic [D_WID-1:0] msg_a,
  input  logic [D_WID-1:0] msg_b,
  input  logic [D_WID-1:0] msg_c,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [D_WID-1:0] dvtc_a,
  output logic [D_WID-1:0] dvtc_b,
  output logic [D_WID-1:0] dvtc_c,
  output logic [2:0]       vtc_en,
  output logic             hard_bit
`ifdef VNODE_SAT_STATS_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  logic                    run_q;
  logic                    s1_vld_q, s2_vld_q;
  logic signed [S_WID-1:0] sum_d, sum_q;
  logic signed [D_WID-1:0] ma_q, mb_q, mc_q;
  logic signed [S_WID-1:0] diff_a, diff_b, diff_c;
  logic signed [D_WID-1:0] sat_a, sat_b, sat_c;
  logic                    clp_a, clp_b, clp_c;
  logic signed [D_WID-1:0] dvtc_a_q, dvtc_b_q, dvtc_c_q;
  logic                    hard_q, clamp_q;
  logic [2:0]              ptr_q;
  logic                    advance, in_xfer, out_xfer;

  // Whole pipe moves together unless a valid output is being back-pressured.
  assign advance  = ~s2_vld_q | out_rdy;
  assign in_rdy   = run_q & advance;
  assign in_xfer  = in_vld & in_rdy;
  assign out_xfer = s2_vld_q & out_rdy;

  assign sum_d = S_WID'($signed(llr_ch)) + S_WID'($signed(msg_a))
               + S_WID'($signed(msg_b)) + S_WID'($signed(msg_c));

  // Each difference equals the sum of the other three operands, so it fits in S_WID.
  assign diff_a = sum_q - S_WID'(ma_q);
  assign diff_b = sum_q - S_WID'(mb_q);
  assign diff_c = sum_q - S_WID'(mc_q);

  vnode_sat #(.D_WID(D_WID), .S_WID(S_WID)) u_sat_a (
    .din_i(diff_a), .dout_o(sat_a), .clamp_o(clp_a)
  );
  vnode_sat #(.D_WID(D_WID), .S_WID(S_WID)) u_sat_b (
    .din_i(diff_b), .dout_o(sat_b), .clamp_o(clp_b)
  );
  vnode_sat #(.D_WID(D_WID), .S_WID(S_WID)) u_sat_c (
    .din_i(diff_c), .dout_o(sat_c), .clamp_o(clp_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      sum_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      mc_q     <= '0;
      dvtc_a_q <= '0;
      dvtc_b_q <= '0;
      dvtc_c_q <= '0;
      hard_q   <= 1'b0;
      clamp_q  <= 1'b0;
      ptr_q    <= VTC_EN_A;
    end else begin
      run_q <= 1'b1;
      if (advance) begin
        s1_vld_q <= in_xfer;
        s2_vld_q <= s1_vld_q;
      end
      if (in_xfer) begin
        sum_q <= sum_d;
        ma_q  <= $signed(msg_a);
        mb_q  <= $signed(msg_b);
        mc_q  <= $signed(msg_c);
      end
      if (advance && s1_vld_q) begin
        dvtc_a_q <= sat_a;
        dvtc_b_q <= sat_b;
        dvtc_c_q <= sat_c;
        hard_q   <= sum_q[S_WID-1];
        clamp_q  <= clp_a | clp_b | clp_c;
      end
      if (out_xfer) ptr_q <= {ptr_q[1:0], ptr_q[2]};
    end
  end

  assign out_vld  = s2_vld_q;
  assign dvtc_a   = dvtc_a_q;
  assign dvtc_b   = dvtc_b_q;
  assign dvtc_c   = dvtc_c_q;
  assign hard_bit = hard_q;
  assign vtc_en   = s2_vld_q ? ptr_q : VTC_EN_OFF;

`ifdef VNODE_SAT_STATS_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt_q <= '0;
    end else if (out_xfer && clamp_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_vnode_proc.sv
// Bench for vnode_proc: directed beats, a queue-based reference model checked on
// every falling edge, and literal expectations for the documented examples.
module tb_vnode_proc;

  localparam int MAXV = 127;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_vld = 1'b0;
  logic       in_rdy;
  logic [7:0] llr_ch = '0, msg_a = '0, msg_b = '0, msg_c = '0;
  logic       out_vld;
  logic       out_rdy = 1'b1;
  logic [7:0] dvtc_a, dvtc_b, dvtc_c;
  logic [2:0] vtc_en;
  logic       hard_bit;
`ifdef VNODE_SAT_STATS_EN
  logic [15:0] sat_cnt;
`endif

  vnode_proc #(.D_WID(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .llr_ch(llr_ch), .msg_a(msg_a), .msg_b(msg_b), .msg_c(msg_c),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .dvtc_a(dvtc_a), .dvtc_b(dvtc_b), .dvtc_c(dvtc_c),
    .vtc_en(vtc_en), .hard_bit(hard_bit)
`ifdef VNODE_SAT_STATS_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int a; int b; int c; bit hb; bit clamp; int acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   xfers = 0;
  int   last_pop = -100;
  int   sat_exp = 0;
  int   m_due;
  bit   m_ev;
  bit   rdy_armed = 1'b0;
  exp_t e;

  function automatic int clampv(input int v);
    if (v > MAXV) return MAXV;
    if (v < -MAXV) return -MAXV;
    return v;
  endfunction

  function automatic exp_t model(input int l, input int a, input int b, input int c,
                                 input int acc);
    exp_t r;
    int s;
    s       = l + a + b + c;
    r.a     = clampv(s - a);
    r.b     = clampv(s - b);
    r.c     = clampv(s - c);
    r.clamp = (r.a != s - a) || (r.b != s - b) || (r.c != s - c);
    r.hb    = (s < 0);
    r.acc   = acc;
    return r;
  endfunction

  function automatic int sv8(input logic [7:0] x);
    return int'($signed(x));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_armed <= 1'b0;
    else          rdy_armed <= 1'b1;
  end

  // Reference: a beat may appear 2 cycles after acceptance, and no earlier than the
  // cycle after its predecessor left.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      xfers    = 0;
      last_pop = -100;
      sat_exp  = 0;
    end else begin
      m_ev = 1'b0;
      if (q.size() > 0) begin
        m_due = (q[0].acc + 2 > last_pop + 1) ? q[0].acc + 2 : last_pop + 1;
        m_ev  = (cyc >= m_due);
      end
      chk("out_vld", int'(out_vld), int'(m_ev));
      chk("in_rdy", int'(in_rdy), int'(rdy_armed && (!m_ev || out_rdy)));
      chk("vtc_en", int'(vtc_en), m_ev ? (1 << (xfers % 3)) : 0);
      if (m_ev && out_vld) begin
        chk("dvtc_a", sv8(dvtc_a), q[0].a);
        chk("dvtc_b", sv8(dvtc_b), q[0].b);
        chk("dvtc_c", sv8(dvtc_c), q[0].c);
        chk("hard_bit", int'(hard_bit), int'(q[0].hb));
      end
`ifdef VNODE_SAT_STATS_EN
      chk("sat_cnt", int'(sat_cnt), sat_exp);
`endif
      if (m_ev && out_rdy) begin
        if (q[0].clamp && sat_exp < 65535) sat_exp++;
        xfers++;
        last_pop = cyc;
        void'(q.pop_front());
      end
      if (in_vld && in_rdy)
        q.push_back(model(sv8(llr_ch), sv8(msg_a), sv8(msg_b), sv8(msg_c), cyc));
    end
    cyc++;
  end

  task automatic drive(input int l, input int a, input int b, input int c);
    llr_ch = 8'(l);
    msg_a  = 8'(a);
    msg_b  = 8'(b);
    msg_c  = 8'(c);
    in_vld = 1'b1;
  endtask

  task automatic send(input int l, input int a, input int b, input int c);
    int n = 0;
    drive(l, a, b, c);
    @(negedge clk);
    while (!in_rdy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_wait", int'(in_rdy), 1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_in_rdy", int'(in_rdy), 0);
    chk("rst_vtc_en", int'(vtc_en), 0);
    chk("rst_dvtc_a", sv8(dvtc_a), 0);
    chk("rst_hard_bit", int'(hard_bit), 0);
    reset_n = 1'b1;
    #1;
    chk("in_rdy_pre_edge", int'(in_rdy), 0);
    @(posedge clk);
    #1;
    chk("in_rdy_post_edge", int'(in_rdy), 1);

    // Model pins for the documented examples.
    e = model(10, 5, -3, 2, 0);
    chk("model_ex_b", e.b, 17);
    e = model(127, 127, 127, 127, 0);
    chk("model_pos_a", e.a, MAXV);
    chk("model_pos_clamp", int'(e.clamp), 1);
    e = model(-128, -128, -128, -128, 0);
    chk("model_neg_c", e.c, -127);
    chk("model_neg_hb", int'(e.hb), 1);

    // Basic example with exact two-cycle latency.
    drive(10, 5, -3, 2);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    chk("lat_cycle1", int'(out_vld), 0);
    @(posedge clk);
    #1;
    chk("lat_cycle2", int'(out_vld), 1);
    chk("ex_dvtc_a", sv8(dvtc_a), 9);
    chk("ex_dvtc_b", sv8(dvtc_b), 17);
    chk("ex_dvtc_c", sv8(dvtc_c), 12);
    chk("ex_hard_bit", int'(hard_bit), 0);
    chk("ex_vtc_en", int'(vtc_en), 1);
    wait_idle();

    // Saturation at both extremes.
    send(127, 127, 127, 127);
    send(-128, -128, -128, -128);
    wait_idle();
`ifdef VNODE_SAT_STATS_EN
    chk("sat_cnt_two", int'(sat_cnt), 2);
`endif

    // Four back-to-back beats.
    send(1, 2, 3, 4);
    send(-5, 6, -7, 8);
    send(100, -100, 50, -60);
    send(-1, 0, 0, 0);
    wait_idle();

    // Back-pressure with the pipeline full, a third beat waiting.
    out_rdy = 1'b0;
    send(20, -10, 30, 5);
    send(-40, 15, -25, 60);
    drive(3, -3, 7, -9);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stall_in_rdy", int'(in_rdy), 0);
    end
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    wait_idle();

    // Reset with two beats in flight.
    send(11, 22, 33, 44);
    send(-11, -22, -33, -44);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_vld", int'(out_vld), 0);
    chk("midrst_vtc_en", int'(vtc_en), 0);
    chk("midrst_in_rdy", int'(in_rdy), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(7, 1, 2, 3);
    begin
      int n = 0;
      while (!out_vld && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("post_rst_vtc_en", int'(vtc_en), 1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
